// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate L1 data cache controller
module dcache_ctrl #(
    parameter int LINES     = 32,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    input  logic [31:0]          p1_addr_i,
    input  logic [31:0]          p1_data_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic                 mem_ack_i,
    input  logic [LINE_BITS-1:0] mem_data_i
);
    localparam int INDEX_W  = $clog2(LINES);
    localparam int OFFSET_W = $clog2(LINE_BITS / 8);
    localparam int TAG_W    = 32 - OFFSET_W - INDEX_W;
    localparam int WSEL_W   = OFFSET_W - 2;

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE, S_REFILL} state_t;

    state_t                 state_q, state_d;
    logic [LINES-1:0]       valid_q, valid_d, dirty_q, dirty_d;
    logic                   mem_enable_q, mem_enable_d, mem_write_q, mem_write_d;
    logic [31:0]            mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0]   mem_data_q, mem_data_d, buf_q, buf_d;
    logic [LINE_BITS-1:0]   data_q [LINES];
    logic [TAG_W-1:0]       tag_q  [LINES];

    logic [INDEX_W-1:0]     index;
    logic [TAG_W-1:0]       tag;
    logic [WSEL_W-1:0]      wsel;
    logic [LINE_BITS-1:0]   cur_line, merged, line_wdata;
    logic                   req, is_write, hit, line_we;
    logic                   unused_addr_lsb;

    assign index           = p1_addr_i[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign tag             = p1_addr_i[31:OFFSET_W+INDEX_W];
    assign wsel            = p1_addr_i[OFFSET_W-1:2];
    assign unused_addr_lsb = ^p1_addr_i[1:0];
    assign cur_line        = data_q[index];
    assign req             = p1_MemRead_i | p1_MemWrite_i;
    assign is_write        = p1_MemWrite_i;
    assign hit             = valid_q[index] && (tag_q[index] == tag);

    assign p1_stall_o   = (state_q != S_IDLE) || (req && !hit);
    assign p1_data_o    = (state_q == S_IDLE && req && hit) ? cur_line[{wsel, 5'b0} +: 32] : 32'h0;
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    always_comb begin
        merged = cur_line;
        merged[{wsel, 5'b0} +: 32] = p1_data_i;
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        buf_d        = buf_q;
        line_we      = 1'b0;
        line_wdata   = merged;
        case (state_q)
            S_IDLE: begin
                if (req && hit && is_write) begin
                    line_we        = 1'b1;
                    dirty_d[index] = 1'b1;
                end else if (req && !hit) begin
                    mem_enable_d = 1'b1;
                    if (valid_q[index] && dirty_q[index]) begin
                        state_d     = S_WRITEBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_q[index], index, {OFFSET_W{1'b0}}};
                        mem_data_d  = cur_line;
                    end else begin
                        state_d     = S_ALLOCATE;
                        mem_write_d = 1'b0;
                        mem_addr_d  = {tag, index, {OFFSET_W{1'b0}}};
                    end
                end
            end
            S_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d     = S_ALLOCATE;
                    mem_write_d = 1'b0;
                    mem_addr_d  = {tag, index, {OFFSET_W{1'b0}}};
                end
            end
            S_ALLOCATE: begin
                if (mem_ack_i) begin
                    state_d      = S_REFILL;
                    buf_d        = mem_data_i;
                    mem_enable_d = 1'b0;
                end
            end
            default: begin
                // Line becomes valid and clean; a pending store merges on the following hit cycle.
                line_we        = 1'b1;
                line_wdata     = buf_q;
                valid_d[index] = 1'b1;
                dirty_d[index] = 1'b0;
                state_d        = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            buf_q        <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            buf_q        <= buf_d;
        end
    end

    // Data and tag arrays are deliberately left uninitialised by reset.
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            data_q[index] <= line_wdata;
            tag_q[index]  <= tag;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl with a line-level cache/memory model
module tb_dcache_ctrl;
    logic         clk = 1'b0;
    logic         rst_i;
    logic         p1_MemRead_i, p1_MemWrite_i;
    logic [31:0]  p1_addr_i, p1_data_i, p1_data_o;
    logic         p1_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;

    dcache_ctrl dut (
        .clk_i(clk), .rst_i(rst_i),
        .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
        .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i), .p1_data_o(p1_data_o),
        .p1_stall_o(p1_stall_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;

    // Model of the cache contents and of backing memory (written-back lines only).
    logic [255:0] m_line [32];
    logic [21:0]  m_tag  [32];
    logic [31:0]  m_valid, m_dirty;
    logic [255:0] mem [logic [31:0]];

    // Current access as seen by the compare process.
    bit           chk = 0, acc_active = 0, acc_write, acc_miss, acc_dirty;
    logic [31:0]  acc_addr, acc_vaddr, acc_rdata;
    logic [255:0] acc_vline;
    int           acc_a, acc_b, cyc;
    int           stall_cnt;
    logic [31:0]  last_rd, wb_addr;
    logic [255:0] wb_line;

    task automatic cmp(input string name, input logic [255:0] got, input logic [255:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        if (mem.exists(la)) return mem[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = {16'hAAAA ^ la[20:5], 16'(w)};
        return l;
    endfunction

    always @(negedge clk) begin
        bit exp_stall, exp_en, exp_wr;
        if (chk) begin
            exp_stall = acc_active && acc_miss && (cyc < acc_b + 2);
            exp_en    = acc_active && acc_miss && cyc >= 1 && cyc <= acc_b;
            exp_wr    = acc_active && acc_dirty && cyc >= 1 && cyc <= acc_a;
            cmp("stall", 256'(p1_stall_o), 256'(exp_stall));
            cmp("mem_enable", 256'(mem_enable_o), 256'(exp_en));
            cmp("mem_write", 256'(mem_write_o), 256'(exp_wr));
            if (exp_en)
                cmp("mem_addr", 256'(mem_addr_o), 256'(exp_wr ? acc_vaddr : {acc_addr[31:5], 5'b0}));
            if (exp_wr)
                cmp("mem_data", mem_data_o, acc_vline);
            if (acc_active && !acc_write && !exp_stall)
                cmp("p1_data", 256'(p1_data_o), 256'(acc_rdata));
            if (acc_active && p1_stall_o) stall_cnt++;
            if (acc_active && !exp_stall) last_rd = p1_data_o;
            if (mem_enable_o && mem_write_o) begin
                wb_addr = mem_addr_o;
                wb_line = mem_data_o;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One request held until it completes; a = writeback ack cycle, b = refill ack cycle.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int a, input int b);
        logic [4:0]   idx;
        logic [21:0]  tg;
        logic [255:0] fill;
        bit           hit;
        int           ncyc;
        idx  = addr[9:5];
        tg   = addr[31:10];
        hit  = m_valid[idx] && (m_tag[idx] == tg);
        fill = mem_line({addr[31:5], 5'b0});
        acc_write = wr;
        acc_addr  = addr;
        acc_miss  = !hit;
        acc_dirty = !hit && m_valid[idx] && m_dirty[idx];
        acc_a     = a;
        acc_b     = hit ? 0 : b;
        acc_vaddr = {m_tag[idx], idx, 5'b0};
        acc_vline = m_line[idx];
        acc_rdata = hit ? m_line[idx][addr[4:2]*32 +: 32] : fill[addr[4:2]*32 +: 32];
        stall_cnt = 0;
        p1_MemRead_i  = !wr;
        p1_MemWrite_i = wr;
        p1_addr_i     = addr;
        p1_data_i     = wd;
        acc_active    = 1;
        ncyc = hit ? 1 : b + 3;
        for (int c = 0; c < ncyc; c++) begin
            cyc        = c;
            mem_ack_i  = !hit && ((acc_dirty && c == a) || c == b);
            mem_data_i = (!hit && c == b) ? fill : '0;
            @(posedge clk);
            #1;
        end
        mem_ack_i  = 0;
        mem_data_i = '0;
        if (!hit) begin
            if (acc_dirty) mem[acc_vaddr] = acc_vline;
            m_line[idx]  = fill;
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            m_line[idx][addr[4:2]*32 +: 32] = wd;
            m_dirty[idx] = 1'b1;
        end
        acc_active    = 0;
        p1_MemRead_i  = 0;
        p1_MemWrite_i = 0;
        idle(1);
    endtask

    initial begin
        rst_i = 0;
        p1_MemRead_i = 0; p1_MemWrite_i = 0; p1_addr_i = 0; p1_data_i = 0;
        mem_ack_i = 0; mem_data_i = '0;
        m_valid = '0; m_dirty = '0;
        idle(2);
        cmp("rst_stall", 256'(p1_stall_o), 256'(0));
        cmp("rst_mem_enable", 256'(mem_enable_o), 256'(0));
        cmp("rst_mem_write", 256'(mem_write_o), 256'(0));
        cmp("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        cmp("rst_mem_data", mem_data_o, 256'(0));
        cmp("rst_p1_data", 256'(p1_data_o), 256'(0));
        rst_i = 1;
        chk = 1;
        idle(2);

        access(0, 32'h0000_0000, 0, 0, 3);
        cmp("t1_stall_cycles", 256'(stall_cnt), 256'(5));
        cmp("t1_data", 256'(last_rd), 256'(32'hAAAA_0000));

        access(0, 32'h0000_0004, 0, 0, 0);
        cmp("t2_stall_cycles", 256'(stall_cnt), 256'(0));
        cmp("t2_data", 256'(last_rd), 256'(32'hAAAA_0001));

        access(1, 32'h0000_0008, 32'h1234_5678, 0, 0);
        cmp("t3_stall_cycles", 256'(stall_cnt), 256'(0));
        access(0, 32'h0000_0008, 0, 0, 0);
        cmp("t3_data", 256'(last_rd), 256'(32'h1234_5678));

        access(0, 32'h0000_0400, 0, 2, 4);
        cmp("t4_stall_cycles", 256'(stall_cnt), 256'(6));
        cmp("t4_wb_addr", 256'(wb_addr), 256'(0));
        cmp("t4_wb_word2", 256'(wb_line[95:64]), 256'(32'h1234_5678));
        access(0, 32'h0000_0404, 0, 0, 0);

        access(1, 32'h0000_0820, 32'hCAFE_F00D, 0, 2);
        cmp("t5_stall_cycles", 256'(stall_cnt), 256'(4));
        access(0, 32'h0000_0820, 0, 0, 0);
        cmp("t5_data", 256'(last_rd), 256'(32'hCAFE_F00D));
        access(0, 32'h0000_0020, 0, 1, 3);
        cmp("t5_wb_addr", 256'(wb_addr), 256'(32'h0000_0820));
        cmp("t5_wb_word0", 256'(wb_line[31:0]), 256'(32'hCAFE_F00D));

        // Reset in the middle of an ALLOCATE handshake.
        chk = 0;
        p1_MemRead_i = 1; p1_addr_i = 32'h0000_0040;
        idle(1);
        cmp("t6_alloc_enable", 256'(mem_enable_o), 256'(1));
        rst_i = 0;
        #1;
        cmp("t6_enable_drop", 256'(mem_enable_o), 256'(0));
        idle(1);
        rst_i = 1;
        p1_MemRead_i = 0;
        m_valid = '0; m_dirty = '0;
        chk = 1;
        idle(1);
        access(0, 32'h0000_0040, 0, 0, 2);
        cmp("t6_remiss_cycles", 256'(stall_cnt), 256'(4));
        access(0, 32'h0000_0400, 0, 0, 1);
        cmp("t6_remiss_400", 256'(stall_cnt), 256'(3));

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
